// File: rtl/gt_mem_pkg.sv
// Shared widths, state encoding and beat-address helper for the victim-cache memory port.
package gt_mem_pkg;

    localparam int BEAT_W     = 64;
    localparam int BEATS      = 4;
    localparam int LINE_W     = BEATS * BEAT_W;
    localparam int ADDR_W     = 32;
    localparam int WORD_IDX_W = 2;
    localparam int LINE_OFF_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-LINE_OFF_W-1:0] base,
        input logic [WORD_IDX_W-1:0]        word
    );
        return {base, word, 3'b000};
    endfunction

endpackage

// File: rtl/gt_beat_ctr.sv
// Beat sequencer: wrapping 2-bit word index with loadable start, plus a 3-bit ack count.
module gt_beat_ctr
    import gt_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [WORD_IDX_W-1:0] i_start,
    input  logic                  i_adv,
    output logic [WORD_IDX_W-1:0] o_idx,
    output logic                  o_done
);

    logic [WORD_IDX_W-1:0] r_idx;
    logic [2:0]            r_cnt;

    // Word index and ack count; load wins over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 2'd0;
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_idx <= i_start;
            r_cnt <= 3'd0;
        end else if (i_adv) begin
            r_idx <= r_idx + 2'd1;
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_idx <= r_idx;
            r_cnt <= r_cnt;
        end
    end

    assign o_idx  = r_idx;
    // Asserted on the ack that brings the count to four.
    assign o_done = i_adv && (r_cnt == 3'(BEATS - 1));

endmodule

// File: rtl/gt_line_mem_port.sv
// Line-to-beat memory port: serialises 256-bit fills/writebacks into four 64-bit beats.
// Optional build macro: GT_MEM_CRITWORD_EN (critical-word-first fill order).
module gt_line_mem_port
    import gt_mem_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] lineAddr,
    input  logic              rdReq,
    input  logic              wrReq,
    input  logic [LINE_W-1:0] toMemData,
    output logic              reqReady,
    output logic [LINE_W-1:0] memData,
    output logic              memDataValid,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRd,
    output logic              memWr,
    output logic [BEAT_W-1:0] memWData,
    input  logic              memAck,
    input  logic [BEAT_W-1:0] memRData
);

    state_e r_state, w_state_nxt;

    logic                          r_req_ready, r_mem_rd, r_mem_wr, r_mem_data_valid;
    logic [ADDR_W-1:0]             r_mem_addr;
    logic [BEAT_W-1:0]             r_mem_wdata;
    logic [LINE_W-1:0]             r_mem_data, r_lbuf, r_wline;
    logic [ADDR_W-LINE_OFF_W-1:0]  r_base;

    logic                          w_req_ready_nxt, w_mem_rd_nxt, w_mem_wr_nxt, w_valid_nxt;
    logic [ADDR_W-1:0]             w_addr_nxt;
    logic [BEAT_W-1:0]             w_wdata_nxt;
    logic [LINE_W-1:0]             w_mem_data_nxt, w_lbuf_nxt;

    logic                          w_accept, w_acc_wr, w_acc_rd, w_fire, w_last;
    logic [WORD_IDX_W-1:0]         w_start, w_word, w_word_inc;
    logic                          w_unused;

    // A simultaneous fill stays pending at the cache while the writeback runs.
    assign w_acc_wr   = r_req_ready && wrReq;
    assign w_acc_rd   = r_req_ready && rdReq && !wrReq;
    assign w_accept   = w_acc_wr || w_acc_rd;
    assign w_fire     = memAck && (r_mem_rd || r_mem_wr);
    assign w_word_inc = w_word + 2'd1;
    assign w_unused   = ^lineAddr[LINE_OFF_W-1:0];

`ifdef GT_MEM_CRITWORD_EN
    assign w_start = w_acc_rd ? lineAddr[4:3] : 2'd0;
`else
    assign w_start = 2'd0;
`endif

    gt_beat_ctr u_beat_ctr (
        .clk     (CLK),
        .rst     (RST),
        .i_load  (w_accept),
        .i_start (w_start),
        .i_adv   (w_fire),
        .o_idx   (w_word),
        .o_done  (w_last)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_acc_wr)      w_state_nxt = WR;
                else if (w_acc_rd) w_state_nxt = RD;
                else               w_state_nxt = IDLE;
            end
            RD:      w_state_nxt = w_last ? RESP : RD;
            WR:      w_state_nxt = w_last ? IDLE : WR;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and the fill line buffer.
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == IDLE);
        w_mem_rd_nxt    = r_mem_rd;
        w_mem_wr_nxt    = r_mem_wr;
        w_valid_nxt     = 1'b0;
        w_addr_nxt      = r_mem_addr;
        w_wdata_nxt     = r_mem_wdata;
        w_mem_data_nxt  = r_mem_data;
        w_lbuf_nxt      = r_lbuf;
        case (r_state)
            IDLE: begin
                if (w_acc_wr) begin
                    w_mem_wr_nxt = 1'b1;
                    w_addr_nxt   = beat_addr(lineAddr[ADDR_W-1:LINE_OFF_W], 2'd0);
                    w_wdata_nxt  = toMemData[BEAT_W-1:0];
                end else if (w_acc_rd) begin
                    w_mem_rd_nxt = 1'b1;
                    w_addr_nxt   = beat_addr(lineAddr[ADDR_W-1:LINE_OFF_W], w_start);
                end else begin
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                end
            end
            RD: begin
                if (w_fire) begin
                    w_lbuf_nxt[int'(w_word) * BEAT_W +: BEAT_W] = memRData;
                    if (w_last) begin
                        // Publish the completed line, including the beat arriving now.
                        w_mem_rd_nxt   = 1'b0;
                        w_mem_data_nxt = w_lbuf_nxt;
                        w_valid_nxt    = 1'b1;
                    end else begin
                        w_addr_nxt = beat_addr(r_base, w_word_inc);
                    end
                end else begin
                    w_mem_rd_nxt = 1'b1;
                end
            end
            WR: begin
                if (w_fire) begin
                    if (w_last) begin
                        w_mem_wr_nxt = 1'b0;
                    end else begin
                        w_addr_nxt  = beat_addr(r_base, w_word_inc);
                        w_wdata_nxt = r_wline[int'(w_word_inc) * BEAT_W +: BEAT_W];
                    end
                end else begin
                    w_mem_wr_nxt = 1'b1;
                end
            end
            RESP: begin
                w_mem_rd_nxt = 1'b0;
                w_mem_wr_nxt = 1'b0;
            end
            default: begin
                w_mem_rd_nxt = 1'b0;
                w_mem_wr_nxt = 1'b0;
            end
        endcase
    end

    // Output and line-buffer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_req_ready      <= 1'b1;
            r_mem_rd         <= 1'b0;
            r_mem_wr         <= 1'b0;
            r_mem_data_valid <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_mem_data       <= '0;
            r_lbuf           <= '0;
        end else begin
            r_req_ready      <= w_req_ready_nxt;
            r_mem_rd         <= w_mem_rd_nxt;
            r_mem_wr         <= w_mem_wr_nxt;
            r_mem_data_valid <= w_valid_nxt;
            r_mem_addr       <= w_addr_nxt;
            r_mem_wdata      <= w_wdata_nxt;
            r_mem_data       <= w_mem_data_nxt;
            r_lbuf           <= w_lbuf_nxt;
        end
    end

    // Request capture at accept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_base  <= '0;
            r_wline <= '0;
        end else if (w_accept) begin
            r_base  <= lineAddr[ADDR_W-1:LINE_OFF_W];
            r_wline <= w_acc_wr ? toMemData : r_wline;
        end else begin
            r_base  <= r_base;
            r_wline <= r_wline;
        end
    end

    assign reqReady     = r_req_ready;
    assign memRd        = r_mem_rd;
    assign memWr        = r_mem_wr;
    assign memDataValid = r_mem_data_valid;
    assign memAddr      = r_mem_addr;
    assign memWData     = r_mem_wdata;
    assign memData      = r_mem_data;

endmodule
